// File: rtl/image_sampling_processor_pkg.sv
// Shared state encoding, UART framing constants and the pixel-pair averager.
// Define ROUND_EN for round-half-up averaging; the default build truncates.
package image_sampling_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_LOAD,
        FETCH_A,
        FETCH_B,
        EXEC,
        PAUSE,
        TX_SEND
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // The 9-bit sum holds 255+255+1 without overflow.
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
`ifdef ROUND_EN
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
`else
        sum = {1'b0, a} + {1'b0, b};
`endif
        return sum[8:1];
    endfunction

endpackage

// File: rtl/image_sampling_processor_if.sv
// Front-panel, UART and external-memory signals of the down-sampling processor.
interface image_sampling_processor_if;
    logic        enablle;
    logic        resume_sw;
    logic        send;
    logic        receive;
    logic        rx;
    logic        tx;
    logic [15:0] toMEM;
    logic [15:0] add_M;
    logic        enable_check;
    logic        pause_LED;
    logic        fetch_LED;
    logic        tx_LED;
    logic        rx_LED;
    logic [15:0] testout;

    modport master (
        output enablle, resume_sw, send, receive, rx,
        input  tx, toMEM, add_M, enable_check, pause_LED, fetch_LED, tx_LED, rx_LED, testout
    );

    modport slave (
        input  enablle, resume_sw, send, receive, rx,
        output tx, toMEM, add_M, enable_check, pause_LED, fetch_LED, tx_LED, rx_LED, testout
    );
endinterface

// File: rtl/image_sampling_processor_uart_8n1.sv
// 8N1 UART: mid-bit sampling receiver with false-start rejection, and a
// transmitter that accepts the next byte during the last stop-bit cycle.
module uart_8n1 import image_sampling_pkg::*; #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       tx,
    output logic       tx_busy
);
    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS + 1);

    logic          rx_prev, rx_act;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic          tx_act, tx_last;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_sh;

    // rx_bit 0 is the start-bit half-period, 1..8 data, 9 the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev  <= 1'b1;
            rx_act   <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_prev  <= rx;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_act) begin
                if (rx_prev && !rx) begin
                    rx_act <= 1'b1;
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt <= '0;
                    if (rx) rx_act <= 1'b0;
                    else    rx_bit <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end else if (rx_cnt == FULL_M1) begin
                rx_cnt <= '0;
                if (rx_bit == LAST_BIT) begin
                    rx_act   <= 1'b0;
                    rx_valid <= 1'b1;
                    rx_ferr  <= (rx != STOP_BIT);
                end else begin
                    rx_sh  <= {rx, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    assign rx_data = rx_sh;

    assign tx_last = tx_act && (tx_bit == LAST_BIT) && (tx_cnt == FULL_M1);
    assign tx_busy = tx_act && !tx_last;
    assign tx      = tx_act ? tx_sh[0] : STOP_BIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_act <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '1;
        end else if (tx_start && !tx_busy) begin
            tx_act <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= {STOP_BIT, tx_data, START_BIT};
        end else if (tx_act) begin
            if (tx_cnt == FULL_M1) begin
                tx_cnt <= '0;
                if (tx_last) begin
                    tx_act <= 1'b0;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                    tx_sh  <= {STOP_BIT, tx_sh[9:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/image_sampling_processor.sv
// Image down-sampler: UART load, in-place pair averaging, UART transmit.
// Optional macro ROUND_EN switches the averager to round-half-up.
module image_sampling_processor import image_sampling_pkg::*; #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int IMG_WORDS    = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    image_sampling_processor_if.slave io
);
    localparam int            HALF_W  = IMG_WORDS / 2;
    localparam int            AW      = (IMG_WORDS > 2) ? $clog2(IMG_WORDS) : 1;
    localparam logic [AW-1:0] LAST_RX = AW'(IMG_WORDS - 1);
    localparam logic [AW-1:0] LAST_I  = AW'(HALF_W - 1);
    localparam logic [AW-1:0] N_OUT   = AW'(HALF_W);

    state_t        state, state_nxt;
    logic [4:0]    sync1, sync2;
    logic [1:0]    edge_d;
    logic          send_rise, recv_rise, en_s, res_s;
    logic          enable_check_r;
    logic [AW-1:0] idx, rx_count, tx_count, addr_a, addr_b;
    logic          clr_i, inc_i, clr_rx, clr_tx, tx_start, rx_wr;
    logic [7:0]    pix_a, pix_b, avg;
    logic [15:0]   add_m_r, to_mem_r, testout_r;
    logic [7:0]    ram [IMG_WORDS];
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr, tx_w, tx_busy;

    // Synchronizer bits: [4] rx, [3] resume_sw, [2] enablle, [1] receive, [0] send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1          <= 5'b10000;
            sync2          <= 5'b10000;
            edge_d         <= 2'b00;
            enable_check_r <= 1'b0;
        end else begin
            sync1          <= {io.rx, io.resume_sw, io.enablle, io.receive, io.send};
            sync2          <= sync1;
            edge_d         <= sync2[1:0];
            enable_check_r <= sync2[2];
        end
    end

    assign send_rise = sync2[0] & ~edge_d[0];
    assign recv_rise = sync2[1] & ~edge_d[1];
    assign en_s      = sync2[2];
    assign res_s     = sync2[3];

    uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (sync2[4]),
        .tx_start (tx_start),
        .tx_data  (ram[tx_count]),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx       (tx_w),
        .tx_busy  (tx_busy)
    );

    assign rx_wr  = (state == RX_LOAD) && rx_valid && !rx_ferr;
    assign addr_a = AW'({idx, 1'b0});
    assign addr_b = addr_a | AW'(1);
    assign avg    = avg8(pix_a, pix_b);

    always_comb begin
        state_nxt = state;
        clr_i     = 1'b0;
        inc_i     = 1'b0;
        clr_rx    = 1'b0;
        clr_tx    = 1'b0;
        tx_start  = 1'b0;
        case (state)
            IDLE: begin
                if (recv_rise) begin
                    state_nxt = RX_LOAD;
                    clr_rx    = 1'b1;
                end else if (en_s) begin
                    state_nxt = FETCH_A;
                    clr_i     = 1'b1;
                end else if (send_rise) begin
                    state_nxt = TX_SEND;
                    clr_tx    = 1'b1;
                end
            end
            RX_LOAD: if (rx_wr && rx_count == LAST_RX) state_nxt = IDLE;
            FETCH_A: state_nxt = FETCH_B;
            FETCH_B: state_nxt = EXEC;
            EXEC: begin
                if (idx == LAST_I) begin
                    state_nxt = IDLE;
                end else if (!en_s) begin
                    state_nxt = PAUSE;
                end else begin
                    inc_i     = 1'b1;
                    state_nxt = FETCH_A;
                end
            end
            PAUSE: begin
                if (en_s && res_s) begin
                    inc_i     = 1'b1;
                    state_nxt = FETCH_A;
                end
            end
            // tx_busy drops in the final stop-bit cycle so frames run back to back.
            TX_SEND: begin
                if (!tx_busy) begin
                    if (tx_count == N_OUT) state_nxt = IDLE;
                    else                   tx_start  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rx_count  <= '0;
            tx_count  <= '0;
            add_m_r   <= '0;
            to_mem_r  <= '0;
            testout_r <= '0;
        end else begin
            state <= state_nxt;
            if (clr_i)       idx <= '0;
            else if (inc_i)  idx <= idx + AW'(1);
            if (clr_rx)      rx_count <= '0;
            else if (rx_wr)  rx_count <= rx_count + AW'(1);
            if (clr_tx)        tx_count <= '0;
            else if (tx_start) tx_count <= tx_count + AW'(1);
            if (state == EXEC) begin
                add_m_r   <= 16'(idx);
                to_mem_r  <= {8'h00, avg};
                testout_r <= {8'(idx), avg};
            end
        end
    end

    // Result i overwrites RAM[i]; its sources 2i and 2i+1 are never behind it.
    always_ff @(posedge clk) begin
        if (rx_wr)              ram[rx_count] <= rx_data;
        else if (state == EXEC) ram[idx]      <= avg;
        if (state == FETCH_A) pix_a <= ram[addr_a];
        if (state == FETCH_B) pix_b <= ram[addr_b];
    end

    assign io.tx           = tx_w;
    assign io.toMEM        = to_mem_r;
    assign io.add_M        = add_m_r;
    assign io.testout      = testout_r;
    assign io.enable_check = enable_check_r;
    assign io.pause_LED    = (state == PAUSE);
    assign io.fetch_LED    = (state == FETCH_A) || (state == FETCH_B);
    assign io.tx_LED       = (state == TX_SEND);
    assign io.rx_LED       = (state == RX_LOAD);

endmodule

// File: tb/tb_image_sampling_processor.sv
// Self-checking bench: fixed pair table plus a random image, both checked
// against an array model of load / pairwise average / transmit.
module tb_image_sampling_processor;
    localparam int CPB = 4;
    localparam int NW  = 8;
    localparam int NH  = NW / 2;
`ifdef ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] avg_t;
        logic [7:0] avg_r;
    } pair_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_sampling_processor_if io();

    image_sampling_processor #(.CLKS_PER_BIT(CPB), .IMG_WORDS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    pair_vec_t  tbl [NH];
    logic [7:0] img [NW];
    logic [7:0] ref_ram [NW];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        io.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            io.rx = d[b];
            repeat (CPB) @(negedge clk);
        end
        io.rx = stop;
        repeat (CPB) @(negedge clk);
        io.rx = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic load_image(input int bad_pos);
        int k;
        io.receive = 1'b1;
        repeat (3) @(negedge clk);
        io.receive = 1'b0;
        k = 0;
        while (!io.rx_LED && k < 20) begin @(negedge clk); k++; end
        chk("rx_LED_on", io.rx_LED, 1);
        for (int n = 0; n < NW; n++) begin
            if (n == bad_pos) begin
                send_byte(8'hA5, 1'b0);
                chk("ferr_discarded", io.rx_LED, 1);
            end
            if (n == NW - 1) chk("rx_LED_before_last", io.rx_LED, 1);
            send_byte(img[n], 1'b1);
            ref_ram[n] = img[n];
        end
        repeat (4) @(negedge clk);
        chk("rx_LED_off", io.rx_LED, 0);
    endtask

    task automatic run_process(input int pause_at, input bit use_tbl);
        int k;
        logic [7:0] exp;
        io.enablle = 1'b1;
        for (int p = 0; p < NH; p++) begin
            k = 0;
            while (!io.fetch_LED && k < 50) begin @(negedge clk); k++; end
            chk("fetch_start", io.fetch_LED, 1);
            if (p == 0) chk("enable_check_hi", io.enable_check, 1);
            io.enablle   = (p == pause_at || p == NH - 1) ? 1'b0 : 1'b1;
            io.resume_sw = 1'b0;
            exp = 8'((int'(ref_ram[2*p]) + int'(ref_ram[2*p+1]) + RND) / 2);
            ref_ram[p] = exp;
            @(negedge clk);
            chk("fetch_b", io.fetch_LED, 1);
            @(negedge clk);
            chk("exec_cycle", io.fetch_LED, 0);
            @(negedge clk);
            chk("add_M", io.add_M, p);
            chk("toMEM", io.toMEM, {8'h00, exp});
            chk("testout", io.testout, {8'(p), exp});
            if (use_tbl) chk("toMEM_tbl", io.toMEM, {8'h00, (RND != 0) ? tbl[p].avg_r : tbl[p].avg_t});
            if (p == pause_at) begin
                chk("pause_LED_on", io.pause_LED, 1);
                repeat (6) @(negedge clk);
                chk("pause_hold", {io.pause_LED, io.fetch_LED, io.enable_check}, 3'b100);
                chk("pause_add_M", io.add_M, p);
                io.enablle   = 1'b1;
                io.resume_sw = 1'b1;
            end
        end
        repeat (6) @(negedge clk);
        chk("idle_after_proc", {io.fetch_LED, io.pause_LED, io.tx_LED, io.rx_LED}, 0);
    endtask

    task automatic transmit();
        int k;
        logic [7:0] d;
        io.send = 1'b1;
        repeat (3) @(negedge clk);
        io.send = 1'b0;
        k = 0;
        while (io.tx && k < 50) begin @(negedge clk); k++; end
        chk("tx_start_seen", io.tx, 0);
        for (int f = 0; f < NH; f++) begin
            repeat (CPB / 2) @(negedge clk);
            chk("tx_start_bit", {io.tx, io.tx_LED}, 2'b01);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                d[b] = io.tx;
            end
            chk("tx_data", d, ref_ram[f]);
            repeat (CPB) @(negedge clk);
            chk("tx_stop_bit", {io.tx, io.tx_LED}, 2'b11);
            repeat (CPB / 2) @(negedge clk);
            if (f < NH - 1) chk("tx_no_gap", io.tx, 0);
            else            chk("tx_done", {io.tx, io.tx_LED}, 2'b10);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'd10,  8'd20,  8'd15,  8'd15};
        tbl[1] = '{8'd30,  8'd31,  8'd30,  8'd31};
        tbl[2] = '{8'd255, 8'd255, 8'd255, 8'd255};
        tbl[3] = '{8'd0,   8'd1,   8'd0,   8'd1};

        io.enablle   = 1'b0;
        io.resume_sw = 1'b0;
        io.send      = 1'b0;
        io.receive   = 1'b0;
        io.rx        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", io.tx, 1);
        chk("rst_toMEM", io.toMEM, 0);
        chk("rst_add_M", io.add_M, 0);
        chk("rst_testout", io.testout, 0);
        chk("rst_leds", {io.pause_LED, io.fetch_LED, io.tx_LED, io.rx_LED, io.enable_check}, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_after_rst", {io.pause_LED, io.fetch_LED, io.tx_LED, io.rx_LED, io.tx}, 5'b00001);

        // Round 1: fixed table, bad frame just before the last byte, pause after first result.
        for (int p = 0; p < NH; p++) begin
            img[2*p]   = tbl[p].a;
            img[2*p+1] = tbl[p].b;
        end
        load_image(NW - 1);
        run_process(0, 1'b1);
        transmit();

        // Round 2: random image, a stray byte while idle, random bad-frame and pause positions.
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        repeat (4) @(negedge clk);
        for (int n = 0; n < NW; n++) img[n] = 8'($urandom_range(0, 255));
        load_image(int'($urandom_range(0, NW - 1)));
        run_process(int'($urandom_range(0, NH - 2)), 1'b0);
        transmit();

        // Asynchronous reset in the middle of a transmit.
        io.send = 1'b1;
        repeat (3) @(negedge clk);
        io.send = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_idle", {io.tx, io.tx_LED}, 2'b10);
        chk("abort_toMEM", io.toMEM, 0);
        chk("abort_testout", io.testout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_idle", {io.pause_LED, io.fetch_LED, io.tx_LED, io.rx_LED, io.tx}, 5'b00001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
